// File: rtl/config_pkg.sv
// Global configuration record shared across the core; blocks derive widths from it.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
   } cfg_t;

   localparam cfg_t EmptyCfg = '{XLEN: 64};

endpackage

// File: rtl/lsu_pkg.sv
// Shared types for the LSU to D-cache request arbitration path.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   typedef enum logic {
      OWN_LD = 1'b0,
      OWN_ST = 1'b1
   } owner_e;

   // Store-buffer drains always write a full dword with byte strobes.
   localparam logic [1:0] SIZE_DWORD = 2'b11;

endpackage

// File: rtl/lsu_starve_ctr.sv
// Saturating count of consecutive load grants taken while a store was waiting.
module lsu_starve_ctr #(
   parameter int unsigned MAX = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int unsigned CNT_W = $clog2(MAX + 1);

   logic [CNT_W-1:0] cnt_reg;

   assign sat = (cnt_reg == CNT_W'(MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (inc && !sat) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/lsu_dcache_arbiter.sv
// Shares the single D-cache request port between LSU loads and store-buffer drains,
// one request outstanding, load priority bounded by starvation and buffer-full override.
module lsu_dcache_arbiter
   import lsu_pkg::*;
#(
   parameter config_pkg::cfg_t Cfg        = config_pkg::EmptyCfg,
   parameter int unsigned      DATA_W     = Cfg.XLEN,
   parameter int unsigned      ADDR_W     = 32,
   parameter int unsigned      TAG_W      = 6,
   parameter int unsigned      SB_W       = 4,
   parameter int unsigned      STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                sb_full_i,
   input  logic                ld_req_valid_i,
   output logic                ld_req_ready_o,
   input  logic [ADDR_W-1:0]   ld_addr_i,
   input  logic [1:0]          ld_size_i,
   input  logic [TAG_W-1:0]    ld_tag_i,
   output logic                ld_resp_valid_o,
   output logic [DATA_W-1:0]   ld_resp_data_o,
   output logic [TAG_W-1:0]    ld_resp_tag_o,
   input  logic                st_req_valid_i,
   output logic                st_req_ready_o,
   input  logic [ADDR_W-1:0]   st_addr_i,
   input  logic [DATA_W-1:0]   st_data_i,
   input  logic [DATA_W/8-1:0] st_strb_i,
   input  logic [SB_W-1:0]     st_sb_id_i,
   output logic                st_resp_valid_o,
   output logic [SB_W-1:0]     st_resp_sb_id_o,
   output logic                dc_req_valid_o,
   input  logic                dc_req_ready_i,
   output logic                dc_req_we_o,
   output logic [ADDR_W-1:0]   dc_req_addr_o,
   output logic [1:0]          dc_req_size_o,
   output logic [DATA_W-1:0]   dc_req_wdata_o,
   output logic [DATA_W/8-1:0] dc_req_strb_o,
   input  logic                dc_resp_valid_i,
   input  logic [DATA_W-1:0]   dc_resp_data_i
);

   localparam int unsigned STRB_W = DATA_W / 8;

   state_e              state_reg;
   owner_e              owner_reg;
   logic                kill_reg;
   logic                we_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [1:0]          size_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [STRB_W-1:0]   strb_reg;
   logic [TAG_W-1:0]    tag_reg;
   logic [SB_W-1:0]     sb_id_reg;
   logic                ld_resp_valid_reg;
   logic [DATA_W-1:0]   ld_resp_data_reg;
   logic [TAG_W-1:0]    ld_resp_tag_reg;
   logic                st_resp_valid_reg;
   logic [SB_W-1:0]     st_resp_sb_id_reg;

   logic idle;
   logic store_wins;
   logic ld_grant;
   logic st_grant;
   logic starve_sat;
   logic kill_now;

   always_comb begin
      idle           = (state_reg == IDLE);
      // Loads win unless the buffer is full, the store has waited long enough, or no load is asking.
      store_wins     = st_req_valid_i & (sb_full_i | starve_sat | ~ld_req_valid_i);
      st_req_ready_o = idle & store_wins & ~rst;
      ld_req_ready_o = idle & ~store_wins & ~flush_i & ~rst;
      ld_grant       = ld_req_valid_i & ld_req_ready_o;
      st_grant       = st_req_valid_i & st_req_ready_o;
      kill_now       = flush_i & (owner_reg == OWN_LD);
   end

   lsu_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk (clk),
      .rst (rst),
      .inc (ld_grant & st_req_valid_i),
      .clr (st_grant),
      .sat (starve_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         owner_reg         <= OWN_LD;
         kill_reg          <= 1'b0;
         we_reg            <= 1'b0;
         addr_reg          <= '0;
         size_reg          <= '0;
         wdata_reg         <= '0;
         strb_reg          <= '0;
         tag_reg           <= '0;
         sb_id_reg         <= '0;
         ld_resp_valid_reg <= 1'b0;
         ld_resp_data_reg  <= '0;
         ld_resp_tag_reg   <= '0;
         st_resp_valid_reg <= 1'b0;
         st_resp_sb_id_reg <= '0;
      end else begin
         ld_resp_valid_reg <= 1'b0;
         st_resp_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (st_grant) begin
                  state_reg <= REQ;
                  owner_reg <= OWN_ST;
                  kill_reg  <= 1'b0;
                  we_reg    <= 1'b1;
                  addr_reg  <= st_addr_i;
                  size_reg  <= SIZE_DWORD;
                  wdata_reg <= st_data_i;
                  strb_reg  <= st_strb_i;
                  sb_id_reg <= st_sb_id_i;
               end else if (ld_grant) begin
                  state_reg <= REQ;
                  owner_reg <= OWN_LD;
                  kill_reg  <= 1'b0;
                  we_reg    <= 1'b0;
                  addr_reg  <= ld_addr_i;
                  size_reg  <= ld_size_i;
                  wdata_reg <= '0;
                  strb_reg  <= '0;
                  tag_reg   <= ld_tag_i;
               end
            end
            REQ: begin
               // A killed load still issues; the cache must see it through to a response.
               if (kill_now) begin
                  kill_reg <= 1'b1;
               end
               if (dc_req_ready_i) begin
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (kill_now) begin
                  kill_reg <= 1'b1;
               end
               if (dc_resp_valid_i) begin
                  state_reg <= IDLE;
                  if (owner_reg == OWN_ST) begin
                     st_resp_valid_reg <= 1'b1;
                     st_resp_sb_id_reg <= sb_id_reg;
                  end else if (!kill_reg && !flush_i) begin
                     ld_resp_valid_reg <= 1'b1;
                     ld_resp_data_reg  <= dc_resp_data_i;
                     ld_resp_tag_reg   <= tag_reg;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign dc_req_valid_o  = (state_reg == REQ);
   assign dc_req_we_o     = we_reg;
   assign dc_req_addr_o   = addr_reg;
   assign dc_req_size_o   = size_reg;
   assign dc_req_wdata_o  = wdata_reg;
   assign dc_req_strb_o   = strb_reg;
   assign ld_resp_valid_o = ld_resp_valid_reg;
   assign ld_resp_data_o  = ld_resp_data_reg;
   assign ld_resp_tag_o   = ld_resp_tag_reg;
   assign st_resp_valid_o = st_resp_valid_reg;
   assign st_resp_sb_id_o = st_resp_sb_id_reg;

endmodule

// File: tb/tb_lsu_dcache_arbiter.sv
// Scoreboard bench: requester drivers, a small cache model, and a negedge monitor
// that checks cache requests and routed responses against expectations pushed at grant time.
module tb_lsu_dcache_arbiter;

   localparam int DW = 64;
   localparam int AW = 32;
   localparam int TW = 6;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          sb_full_i;
   logic          ld_req_valid_i;
   logic          ld_req_ready_o;
   logic [AW-1:0] ld_addr_i;
   logic [1:0]    ld_size_i;
   logic [TW-1:0] ld_tag_i;
   logic          ld_resp_valid_o;
   logic [DW-1:0] ld_resp_data_o;
   logic [TW-1:0] ld_resp_tag_o;
   logic          st_req_valid_i;
   logic          st_req_ready_o;
   logic [AW-1:0] st_addr_i;
   logic [DW-1:0] st_data_i;
   logic [7:0]    st_strb_i;
   logic [SW-1:0] st_sb_id_i;
   logic          st_resp_valid_o;
   logic [SW-1:0] st_resp_sb_id_o;
   logic          dc_req_valid_o;
   logic          dc_req_ready_i;
   logic          dc_req_we_o;
   logic [AW-1:0] dc_req_addr_o;
   logic [1:0]    dc_req_size_o;
   logic [DW-1:0] dc_req_wdata_o;
   logic [7:0]    dc_req_strb_o;
   logic          dc_resp_valid_i;
   logic [DW-1:0] dc_resp_data_i;

   always #5 clk = ~clk;

   lsu_dcache_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .flush_i         (flush_i),
      .sb_full_i       (sb_full_i),
      .ld_req_valid_i  (ld_req_valid_i),
      .ld_req_ready_o  (ld_req_ready_o),
      .ld_addr_i       (ld_addr_i),
      .ld_size_i       (ld_size_i),
      .ld_tag_i        (ld_tag_i),
      .ld_resp_valid_o (ld_resp_valid_o),
      .ld_resp_data_o  (ld_resp_data_o),
      .ld_resp_tag_o   (ld_resp_tag_o),
      .st_req_valid_i  (st_req_valid_i),
      .st_req_ready_o  (st_req_ready_o),
      .st_addr_i       (st_addr_i),
      .st_data_i       (st_data_i),
      .st_strb_i       (st_strb_i),
      .st_sb_id_i      (st_sb_id_i),
      .st_resp_valid_o (st_resp_valid_o),
      .st_resp_sb_id_o (st_resp_sb_id_o),
      .dc_req_valid_o  (dc_req_valid_o),
      .dc_req_ready_i  (dc_req_ready_i),
      .dc_req_we_o     (dc_req_we_o),
      .dc_req_addr_o   (dc_req_addr_o),
      .dc_req_size_o   (dc_req_size_o),
      .dc_req_wdata_o  (dc_req_wdata_o),
      .dc_req_strb_o   (dc_req_strb_o),
      .dc_resp_valid_i (dc_resp_valid_i),
      .dc_resp_data_i  (dc_resp_data_i)
   );

   typedef struct { logic [AW-1:0] addr; logic [1:0] size; logic [TW-1:0] tag; } ld_item_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [7:0] strb; logic [SW-1:0] id; } st_item_t;
   typedef struct { logic we; logic [AW-1:0] addr; logic [1:0] size; logic [DW-1:0] wdata; logic [7:0] strb; } dc_item_t;
   typedef struct { logic [DW-1:0] data; logic [TW-1:0] tag; } ld_exp_t;

   ld_item_t      ld_q[$];
   st_item_t      st_q[$];
   dc_item_t      dc_exp[$];
   ld_exp_t       ld_exp[$];
   logic [SW-1:0] st_exp[$];
   bit            grant_log[$];   // 0 = load grant, 1 = store grant

   int checks = 0;
   int errors = 0;
   int ld_grants = 0;
   int ld_resp_cnt = 0;
   int st_resp_cnt = 0;
   int stalled = 0;
   int resp_lat = 0;
   int stall_cnt = 0;
   bit cache_busy = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
      return (a == 32'h1000) ? 64'hDEAD : {~a, a};
   endfunction

   // load requester
   initial begin
      ld_req_valid_i = 1'b0;
      ld_addr_i = '0;
      ld_size_i = '0;
      ld_tag_i  = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst && ld_q.size() > 0) begin
            ld_req_valid_i = 1'b1;
            ld_addr_i = ld_q[0].addr;
            ld_size_i = ld_q[0].size;
            ld_tag_i  = ld_q[0].tag;
         end else begin
            ld_req_valid_i = 1'b0;
         end
      end
   end

   // store-buffer drain requester
   initial begin
      st_req_valid_i = 1'b0;
      st_addr_i  = '0;
      st_data_i  = '0;
      st_strb_i  = '0;
      st_sb_id_i = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst && st_q.size() > 0) begin
            st_req_valid_i = 1'b1;
            st_addr_i  = st_q[0].addr;
            st_data_i  = st_q[0].data;
            st_strb_i  = st_q[0].strb;
            st_sb_id_i = st_q[0].id;
         end else begin
            st_req_valid_i = 1'b0;
         end
      end
   end

   // cache model: optional accept stall, then a response resp_lat cycles after acceptance
   initial begin
      int lat;
      logic nv, nr, p_we;
      logic [AW-1:0] p_addr;
      lat = 0; p_we = 1'b0; p_addr = '0;
      dc_req_ready_i  = 1'b1;
      dc_resp_valid_i = 1'b0;
      dc_resp_data_i  = '0;
      forever begin
         @(negedge clk);
         nv = 1'b0;
         if (dc_req_valid_o && dc_req_ready_i && !rst) begin
            cache_busy = 1'b1;
            lat = resp_lat;
            p_we = dc_req_we_o;
            p_addr = dc_req_addr_o;
         end else if (dc_req_valid_o && !dc_req_ready_i && stall_cnt > 0) begin
            stall_cnt--;
         end
         if (cache_busy) begin
            if (lat == 0) begin
               nv = 1'b1;
               cache_busy = 1'b0;
            end else begin
               lat--;
            end
         end
         nr = (stall_cnt == 0);
         @(posedge clk); #1;
         dc_req_ready_i  = nr;
         dc_resp_valid_i = nv;
         dc_resp_data_i  = p_we ? {$urandom, $urandom} : mem_data(p_addr);
      end
   end

   // monitor / scoreboard
   initial begin
      ld_item_t li;
      st_item_t si;
      dc_item_t de;
      ld_exp_t  le;
      logic [SW-1:0] sid;
      logic ld_hs, st_hs;
      forever begin
         @(negedge clk);
         if (!rst) begin
            ld_hs = ld_req_valid_i && ld_req_ready_o;
            st_hs = st_req_valid_i && st_req_ready_o;
            if (ld_hs && st_hs) check("dual_grant", 64'(1), 64'(0));
            if (ld_hs && ld_q.size() > 0) begin
               li = ld_q.pop_front();
               ld_exp.push_back('{mem_data(li.addr), li.tag});
               dc_exp.push_back('{1'b0, li.addr, li.size, '0, '0});
               grant_log.push_back(1'b0);
               ld_grants++;
            end
            if (st_hs && st_q.size() > 0) begin
               si = st_q.pop_front();
               st_exp.push_back(si.id);
               dc_exp.push_back('{1'b1, si.addr, 2'b11, si.data, si.strb});
               grant_log.push_back(1'b1);
            end
            if (dc_req_valid_o) begin
               if (dc_exp.size() == 0) begin
                  check("dc_req_unexpected", 64'(1), 64'(0));
               end else if (!dc_req_ready_i) begin
                  stalled++;
                  check("stall_addr", 64'(dc_req_addr_o), 64'(dc_exp[0].addr));
                  check("stall_wdata", dc_req_wdata_o, dc_exp[0].wdata);
               end else begin
                  de = dc_exp.pop_front();
                  check("dc_we", 64'(dc_req_we_o), 64'(de.we));
                  check("dc_addr", 64'(dc_req_addr_o), 64'(de.addr));
                  check("dc_size", 64'(dc_req_size_o), 64'(de.size));
                  check("dc_wdata", dc_req_wdata_o, de.wdata);
                  check("dc_strb", 64'(dc_req_strb_o), 64'(de.strb));
               end
            end
            if (ld_resp_valid_o) begin
               ld_resp_cnt++;
               if (ld_exp.size() == 0) begin
                  check("ld_resp_unexpected", 64'(1), 64'(0));
               end else begin
                  le = ld_exp.pop_front();
                  $display("ld resp tag=%0d data=0x%0h", ld_resp_tag_o, ld_resp_data_o);
                  check("ld_resp_data", ld_resp_data_o, le.data);
                  check("ld_resp_tag", 64'(ld_resp_tag_o), 64'(le.tag));
               end
            end
            if (st_resp_valid_o) begin
               st_resp_cnt++;
               if (st_exp.size() == 0) begin
                  check("st_resp_unexpected", 64'(1), 64'(0));
               end else begin
                  sid = st_exp.pop_front();
                  $display("st resp sb_id=%0d", st_resp_sb_id_o);
                  check("st_resp_sb_id", 64'(st_resp_sb_id_o), 64'(sid));
               end
            end
         end
      end
   end

   task automatic wait_quiet(input string tag);
      int n;
      n = 0;
      while ((ld_q.size() > 0 || st_q.size() > 0 || ld_exp.size() > 0 || st_exp.size() > 0 ||
              cache_busy || dc_resp_valid_i) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check({tag, "_timeout"}, 64'(1), 64'(0));
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic wait_ld_grant(input string tag);
      int n, g0;
      n = 0;
      g0 = ld_grants;
      while (ld_grants == g0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check({tag, "_grant_timeout"}, 64'(1), 64'(0));
   endtask

   function automatic int store_pos();
      for (int i = 0; i < grant_log.size(); i++) if (grant_log[i]) return i;
      return -1;
   endfunction

   initial begin
      int r0;
      rst = 1'b1;
      flush_i = 1'b0;
      sb_full_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ld_ready", 64'(ld_req_ready_o), 64'(0));
      check("rst_st_ready", 64'(st_req_ready_o), 64'(0));
      check("rst_dc_valid", 64'(dc_req_valid_o), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_dc_valid", 64'(dc_req_valid_o), 64'(0));
      check("post_rst_ld_resp", 64'(ld_resp_valid_o), 64'(0));
      check("post_rst_st_resp", 64'(st_resp_valid_o), 64'(0));
      check("post_rst_ld_ready", 64'(ld_req_ready_o), 64'(1));
      @(posedge clk); #1;

      // lone load
      resp_lat = 1;
      ld_q.push_back('{32'h1000, 2'b11, 6'd5});
      wait_quiet("lone_load");
      check("lone_ld_count", 64'(ld_resp_cnt), 64'(1));
      check("lone_st_count", 64'(st_resp_cnt), 64'(0));

      // continuous loads with one waiting store: store gets in after STARVE_MAX loads
      resp_lat = 0;
      grant_log.delete();
      for (int i = 0; i < 12; i++) ld_q.push_back('{32'h2000 + 32'(i * 8), 2'(i), 6'(10 + i)});
      st_q.push_back('{32'h3000, {$urandom, $urandom}, 8'($urandom), 4'd3});
      wait_quiet("starve");
      check("starve_loads_before_store", 64'(store_pos()), 64'(8));
      check("starve_total_grants", 64'(grant_log.size()), 64'(13));

      // load and store together, counter cleared: load first
      grant_log.delete();
      ld_q.push_back('{32'h4000, 2'b10, 6'd30});
      st_q.push_back('{32'h4100, {$urandom, $urandom}, 8'hF0, 4'd7});
      wait_quiet("both");
      check("both_store_pos", 64'(store_pos()), 64'(1));
      check("both_grants", 64'(grant_log.size()), 64'(2));

      // buffer full forces store first
      sb_full_i = 1'b1;
      grant_log.delete();
      ld_q.push_back('{32'h5000, 2'b01, 6'd31});
      st_q.push_back('{32'h5100, {$urandom, $urandom}, 8'h0F, 4'd9});
      wait_quiet("sb_full");
      check("sb_full_store_pos", 64'(store_pos()), 64'(0));
      sb_full_i = 1'b0;

      // flush during WAIT drops the load response
      resp_lat = 4;
      ld_q.push_back('{32'h6000, 2'b11, 6'd40});
      wait_ld_grant("flush");
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush_i = 1'b1;
      if (ld_exp.size() > 0) void'(ld_exp.pop_back());
      @(posedge clk); #1;
      flush_i = 1'b0;
      r0 = ld_resp_cnt;
      wait_quiet("flush");
      check("flush_no_resp", 64'(ld_resp_cnt), 64'(r0));
      resp_lat = 0;
      ld_q.push_back('{32'h6100, 2'b11, 6'd41});
      wait_quiet("after_flush");
      check("after_flush_resp", 64'(ld_resp_cnt), 64'(r0 + 1));

      // cache holds ready low for 5 cycles
      stalled = 0;
      stall_cnt = 5;
      ld_q.push_back('{32'h7000, 2'b00, 6'd50});
      wait_quiet("stall");
      check("stall_cycles", 64'(stalled), 64'(5));

      // reset mid-WAIT, late cache response must be ignored
      resp_lat = 4;
      ld_q.push_back('{32'h8000, 2'b11, 6'd60});
      wait_ld_grant("rst_mid");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      ld_q.delete(); st_q.delete(); ld_exp.delete(); st_exp.delete(); dc_exp.delete();
      @(negedge clk);
      check("mid_rst_ld_ready", 64'(ld_req_ready_o), 64'(0));
      check("mid_rst_st_ready", 64'(st_req_ready_o), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_dc_valid", 64'(dc_req_valid_o), 64'(0));
      check("mid_rst_ld_resp", 64'(ld_resp_valid_o), 64'(0));
      check("mid_rst_st_resp", 64'(st_resp_valid_o), 64'(0));
      check("mid_rst_idle", 64'(ld_req_ready_o), 64'(1));
      @(posedge clk); #1;
      r0 = ld_resp_cnt;
      wait_quiet("late_resp");
      check("late_resp_ignored", 64'(ld_resp_cnt), 64'(r0));
      resp_lat = 0;
      ld_q.push_back('{32'h9000, 2'b11, 6'd61});
      wait_quiet("after_rst");
      check("after_rst_resp", 64'(ld_resp_cnt), 64'(r0 + 1));

      check("ld_exp_empty", 64'(ld_exp.size()), 64'(0));
      check("st_exp_empty", 64'(st_exp.size()), 64'(0));
      check("dc_exp_empty", 64'(dc_exp.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/lsu_dcache_arbiter.md
# lsu_dcache_arbiter

Shares the single D-cache request port between the LSU load path (loads issued from the LSU reservation station) and the store-buffer drain path (committed stores). It keeps one request outstanding at a time. It arbitrates with load priority, bounded by a store-starvation counter and a store-buffer-full override, and routes each cache response back to the requester that owns it. It sits between the LSU execute stage / store buffer and the D-cache, and it drops load responses on pipeline flush.

## Interface
Parameters:
- Cfg, config_pkg::EmptyCfg, global configuration
- DATA_W, Cfg.XLEN, data width; strobe width is DATA_W/8
- ADDR_W, 32, address width
- TAG_W, 6, load destination tag width
- SB_W, 4, store-buffer entry id width
- STARVE_MAX, 8, maximum number of consecutive load grants while a store waits

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  kills the in-flight load and blocks load acceptance this cycle
- sb_full_i  in  1  store buffer full; forces store priority
- ld_req_valid_i / ld_req_ready_o  in/out  1  load request handshake
- ld_addr_i  in  ADDR_W  load address
- ld_size_i  in  2  load size (00 byte … 11 dword)
- ld_tag_i  in  TAG_W  load destination tag
- ld_resp_valid_o  out  1  load data-return pulse
- ld_resp_data_o  out  DATA_W  returned data
- ld_resp_tag_o  out  TAG_W  tag of the returned load
- st_req_valid_i / st_req_ready_o  in/out  1  store drain handshake
- st_addr_i  in  ADDR_W  store address
- st_data_i  in  DATA_W  store data
- st_strb_i  in  DATA_W/8  byte strobes
- st_sb_id_i  in  SB_W  store-buffer id
- st_resp_valid_o  out  1  store-complete pulse
- st_resp_sb_id_o  out  SB_W  id of the completed store
- dc_req_valid_o / dc_req_ready_i  out/in  1  cache request handshake
- dc_req_we_o  out  1  1 = store
- dc_req_addr_o  out  ADDR_W  request address
- dc_req_size_o  out  2  request size; 11 for stores
- dc_req_wdata_o  out  DATA_W  write data
- dc_req_strb_o  out  DATA_W/8  write strobes
- dc_resp_valid_i  in  1  cache response pulse
- dc_resp_data_i  in  DATA_W  response data

## Operation
- FSM states: IDLE → REQ → WAIT → IDLE. Reset enters IDLE, clears the owner/kill flags and starvation counter, and zeroes all valid outputs. Readies are 0 while rst is high.
- **IDLE arbitration:**
  - store_wins = st_req_valid_i & (sb_full_i | starve_cnt == STARVE_MAX | !ld_req_valid_i).
  - st_req_ready_o = IDLE & store_wins.
  - ld_req_ready_o = IDLE & !store_wins & !flush_i.
- **Acceptance:** the accepted request is captured into the request register along with owner (LD/ST). The FSM moves to REQ.
- **Starvation counter:**
  - Saturating, width $clog2(STARVE_MAX+1).
  - Increments on a load grant while st_req_valid_i is high.
  - Clears on a store grant.
- **REQ:** dc_req_valid_o is held high with stable payload until dc_req_ready_i, then the FSM moves to WAIT. The request is never withdrawn, even if killed.
- **WAIT:** on dc_resp_valid_i the FSM returns to IDLE.
  - Owner ST: st_resp_valid_o pulses with the sb_id.
  - Owner LD and not killed (including flush_i that same cycle): ld_resp_valid_o pulses with data and tag.
- **Kill:** flush_i in REQ or WAIT with owner LD sets kill. The response is still consumed but not forwarded. Stores are never killed.
- A cache response outside WAIT is ignored.

## Timing
- Requester handshake in cycle N → dc_req_valid_o in N+1 (registered).
- dc_resp_valid_i in cycle M → ld/st_resp_valid_o in M+1 (registered). The FSM is IDLE in M+1, so a new grant is possible in M+1.
- Minimum turnaround is 3 cycles per request with zero-latency cache acceptance and response.
- Response outputs are single-cycle pulses. Data and tag hold their values until the next response.

## Structure
- Put state_e {IDLE, REQ, WAIT} and owner_e {OWN_LD, OWN_ST} in lsu_pkg. Define no new config fields.
- One natural sub-module: lsu_starve_ctr (saturating counter with inc/clr/sat flag). Everything else is flat.

## Test plan
- Lone load 0x1000, tag 5; cache ready immediately, responds 2 cycles later with 0xDEAD → ld_resp_valid_o, data 0xDEAD, tag 5. No store pulse.
- Load and store valid together, sb_full_i=0, counter 0 → load granted first, store granted on the next IDLE, st_resp_sb_id_o matches.
- Continuous loads plus a waiting store, STARVE_MAX=8 → exactly 8 load grants, then the store is granted and the counter clears.
- sb_full_i=1 with both requests valid → store granted immediately.
- flush_i during WAIT of a load → no ld_resp_valid_o. FSM returns to IDLE on the response. The next load completes normally.
- dc_req_ready_i held low 5 cycles → dc_req_valid_o and payload stable all 5 cycles. rst asserted mid-WAIT → IDLE next cycle, all valids 0, late cache response ignored.
